// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types, defaults and the rotating-priority search
// used by stream_mux_arb and rr_arbiter.
//   mux_mode_t    - MODE input encoding (fixed select / round-robin)
//   lock_state_t  - packet lock state (used when STREAM_MUX_LOCK_EN is defined)
//   rr_pick_t     - result of rr_next: found flag + grant index
//   rr_next()     - first valid requester after LAST, modulo n (n <= RR_MAX_N)
package stream_mux_pkg;

   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

   typedef enum logic {LOCK_IDLE = 1'b0, LOCK_HELD = 1'b1} lock_state_t;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_N     = 4;

   // The search works on a fixed-width request vector so it can live in a
   // package; callers zero-extend their N-bit request into it.
   localparam int unsigned RR_MAX_N  = 64;
   localparam int unsigned RR_IDXW   = 6;

   typedef struct packed {
      logic               found;
      logic [RR_IDXW-1:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_next(input logic [RR_MAX_N-1:0] valid,
                                        input int unsigned         n,
                                        input int unsigned         last);
      rr_pick_t    pick;
      int unsigned idx;
      pick = '0;
      for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
         idx = (last + k) % n;
         if (k <= n && !pick.found && valid[idx[RR_IDXW-1:0]]) begin
            pick.found = 1'b1;
            pick.idx   = idx[RR_IDXW-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter: N-way rotating-priority arbiter.
//   clk, rst  - clock, synchronous active-high reset (LAST resets to N-1)
//   req       - per-channel request
//   advance   - strobe: load LAST with adv_idx at the next edge
//   adv_idx   - channel that actually transferred (may differ from gnt_idx
//               when the parent overrides the round-robin pick)
//   gnt_oh    - one-hot round-robin pick (zero when no request)
//   gnt_idx   - index of the pick (don't-care when gnt_oh is zero)
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned  N    = DEF_N,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            advance,
   input  logic [SELW-1:0] adv_idx,
   output logic [N-1:0]    gnt_oh,
   output logic [SELW-1:0] gnt_idx
);

   logic [SELW-1:0]     last_q, last_d;
   logic [RR_MAX_N-1:0] req_ext;
   int unsigned         last_u;
   rr_pick_t            pick;

   always_comb begin
      req_ext         = '0;
      req_ext[N-1:0]  = req;
      last_u          = 32'(last_q);
      pick            = rr_next(req_ext, N, last_u);
      gnt_idx         = pick.idx[SELW-1:0];
      gnt_oh          = '0;
      if (pick.found) begin
         gnt_oh[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      last_d = last_q;
      if (advance) begin
         last_d = adv_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= SELW'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N:1 valid/ready stream multiplexer with a registered,
// full-throughput output stage. Source is SEL (MODE=0) or round-robin among
// valid channels (MODE=1).
//   CLK, RST   - clock, synchronous active-high reset
//   MODE, SEL  - source selection (SEL >= N never grants)
//   IN_VALID   - per-channel valid
//   IN_DATA    - channel i at [i*WIDTH +: WIDTH]
//   IN_READY   - combinational accept, at most one bit set, 0 during RST
//   OUT_VALID, OUT_DATA, OUT_SEL - registered beat and its source channel
//   OUT_READY  - consumer accept
// Optional (macro STREAM_MUX_LOCK_EN): IN_LAST / OUT_LAST; a beat with
// IN_LAST=0 locks the grant to its channel until a last beat transfers.
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter int unsigned  WIDTH = DEF_WIDTH,
   parameter int unsigned  N     = DEF_N,
   localparam int unsigned SELW  = $clog2(N)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               MODE,
   input  logic [SELW-1:0]    SEL,
   input  logic [N-1:0]       IN_VALID,
   input  logic [N*WIDTH-1:0] IN_DATA,
   output logic [N-1:0]       IN_READY,
`ifdef STREAM_MUX_LOCK_EN
   input  logic [N-1:0]       IN_LAST,
   output logic               OUT_LAST,
`endif
   output logic               OUT_VALID,
   output logic [WIDTH-1:0]   OUT_DATA,
   output logic [SELW-1:0]    OUT_SEL,
   input  logic               OUT_READY
);

   mux_mode_t        mode;
   logic             ld;
   logic             xfer;
   logic [N-1:0]     gnt_oh;
   logic [SELW-1:0]  gnt_idx;
   logic [N-1:0]     arb_oh;
   logic [SELW-1:0]  arb_idx;
   logic             locked;
   logic [SELW-1:0]  lock_idx;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_sel_q,   out_sel_d;

   rr_arbiter #(.N(N)) u_arb (
      .clk     (CLK),
      .rst     (RST),
      .req     (IN_VALID),
      .advance (xfer),
      .adv_idx (gnt_idx),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx)
   );

`ifdef STREAM_MUX_LOCK_EN
   lock_state_t     lock_state_q, lock_state_d;
   logic [SELW-1:0] lock_idx_q,   lock_idx_d;
   logic            out_last_q,   out_last_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         lock_state_q <= LOCK_IDLE;
         lock_idx_q   <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         lock_idx_q   <= lock_idx_d;
      end
   end

   always_comb begin
      lock_state_d = lock_state_q;
      lock_idx_d   = lock_idx_q;
      if (xfer) begin
         lock_idx_d   = gnt_idx;
         lock_state_d = IN_LAST[gnt_idx] ? LOCK_IDLE : LOCK_HELD;
      end
   end

   always_comb begin
      locked   = (lock_state_q == LOCK_HELD);
      lock_idx = lock_idx_q;
   end

   always_comb begin
      out_last_d = out_last_q;
      if (xfer) begin
         out_last_d = IN_LAST[gnt_idx];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_last_q <= 1'b0;
      end else begin
         out_last_q <= out_last_d;
      end
   end

   assign OUT_LAST = out_last_q;
`else
   always_comb begin
      locked   = 1'b0;
      lock_idx = '0;
   end
`endif

   // Grant selection. A lock overrides MODE/SEL; the arbiter's LAST still
   // follows whichever channel actually transferred.
   always_comb begin
      mode    = mux_mode_t'(MODE);
      ld      = !out_valid_q || OUT_READY;
      gnt_oh  = '0;
      gnt_idx = '0;
      if (locked) begin
         gnt_idx = lock_idx;
         for (int unsigned i = 0; i < N; i++) begin
            if (lock_idx == SELW'(i)) begin
               gnt_oh[i] = IN_VALID[i];
            end
         end
      end else if (mode == MODE_RR) begin
         gnt_idx = arb_idx;
         gnt_oh  = arb_oh;
      end else begin
         gnt_idx = SEL;
         // Out-of-range SEL matches no channel, so it never grants.
         for (int unsigned i = 0; i < N; i++) begin
            if (SEL == SELW'(i)) begin
               gnt_oh[i] = IN_VALID[i];
            end
         end
      end
      if (RST) begin
         gnt_oh = '0;
      end
      IN_READY = ld ? gnt_oh : '0;
      xfer     = ld && (|gnt_oh);
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (ld) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = IN_DATA[32'(gnt_idx) * WIDTH +: WIDTH];
            out_sel_d  = gnt_idx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed vectors for stream_mux_arb (N=4, WIDTH=32) plus
// a short sequence on an N=3, WIDTH=8 instance for the non-power-of-two case.
// The packet-lock sequence is compiled only with STREAM_MUX_LOCK_EN.
module tb_stream_mux_arb;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;
   localparam logic [31:0] D3 = 32'h4444_0003;

   typedef struct {
      logic        rst;
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_od;
      logic [1:0]  exp_os;
   } vec_t;

   logic         clk;
   logic         rst, mode, ordy;
   logic [1:0]   sel;
   logic [3:0]   vld, rdy;
   logic [127:0] in_data;
   logic         ov;
   logic [31:0]  od;
   logic [1:0]   os;

   logic         rst3, mode3, ordy3;
   logic [1:0]   sel3;
   logic [2:0]   vld3, rdy3;
   logic [23:0]  in_data3;
   logic         ov3;
   logic [7:0]   od3;
   logic [1:0]   os3;

`ifdef STREAM_MUX_LOCK_EN
   logic [3:0]   in_last;
   logic         out_last;
   logic [2:0]   in_last3;
   logic         out_last3;
`endif

   int checks   = 0;
   int failures = 0;

   stream_mux_arb #(.WIDTH(32), .N(4)) dut (
      .CLK       (clk),
      .RST       (rst),
      .MODE      (mode),
      .SEL       (sel),
      .IN_VALID  (vld),
      .IN_DATA   (in_data),
      .IN_READY  (rdy),
`ifdef STREAM_MUX_LOCK_EN
      .IN_LAST   (in_last),
      .OUT_LAST  (out_last),
`endif
      .OUT_VALID (ov),
      .OUT_DATA  (od),
      .OUT_SEL   (os),
      .OUT_READY (ordy)
   );

   stream_mux_arb #(.WIDTH(8), .N(3)) dut3 (
      .CLK       (clk),
      .RST       (rst3),
      .MODE      (mode3),
      .SEL       (sel3),
      .IN_VALID  (vld3),
      .IN_DATA   (in_data3),
      .IN_READY  (rdy3),
`ifdef STREAM_MUX_LOCK_EN
      .IN_LAST   (in_last3),
      .OUT_LAST  (out_last3),
`endif
      .OUT_VALID (ov3),
      .OUT_DATA  (od3),
      .OUT_SEL   (os3),
      .OUT_READY (ordy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, check IN_READY mid-cycle, check registered
   // outputs 1 time unit after the rising edge.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      rst  = v.rst;
      mode = v.mode;
      sel  = v.sel;
      vld  = v.vld;
      ordy = v.ordy;
      #1;
      chk({tag, ".in_ready"}, 64'(rdy), 64'(v.exp_rdy));
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 64'(ov), 64'(v.exp_ov));
      chk({tag, ".out_data"},  64'(od), 64'(v.exp_od));
      chk({tag, ".out_sel"},   64'(os), 64'(v.exp_os));
   endtask

   task automatic step3(input logic m, input logic [1:0] s, input logic [2:0] v,
                        input logic [2:0] e_rdy, input logic e_ov,
                        input logic [7:0] e_od, input logic [1:0] e_os,
                        input string tag);
      @(negedge clk);
      rst3  = 1'b0;
      mode3 = m;
      sel3  = s;
      vld3  = v;
      ordy3 = 1'b1;
      #1;
      chk({tag, ".in_ready"}, 64'(rdy3), 64'(e_rdy));
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 64'(ov3), 64'(e_ov));
      chk({tag, ".out_data"},  64'(od3), 64'(e_od));
      chk({tag, ".out_sel"},   64'(os3), 64'(e_os));
   endtask

   vec_t vecs[28];

   initial begin
      // rst mode sel vld ordy | rdy ov od os
      vecs[0]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0};
      vecs[1]  = '{1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, D2,    2'd2};
      vecs[2]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0};
      vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0,    2'd0};
      vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, D1,    2'd1};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, D2,    2'd2};
      vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, D3,    2'd3};
      vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0,    2'd0};
      vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, D1,    2'd1};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, D2,    2'd2};
      vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, D3,    2'd3};
      vecs[11] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, D3,    2'd3};
      vecs[12] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, D3,    2'd3};
      vecs[13] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, D3,    2'd3};
      vecs[14] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0,    2'd0};
      vecs[15] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, D1,    2'd1};
      vecs[16] = '{1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, D0,    2'd0};
      vecs[17] = '{1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, 1'b1, D1,    2'd1};
      vecs[18] = '{1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, D0,    2'd0};
      vecs[19] = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, D0,    2'd0};
      vecs[20] = '{1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, D0,    2'd0};
      vecs[21] = '{1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, D1,    2'd1};
      vecs[22] = '{1'b0, 1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, D1,    2'd1};
      vecs[23] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, D1,    2'd1};
      vecs[24] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, D2,    2'd2};
      vecs[25] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, D2,    2'd2};
      vecs[26] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0};
      vecs[27] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0001, 1'b1, D0,    2'd0};

      rst      = 1'b1;
      mode     = 1'b0;
      sel      = 2'd0;
      vld      = 4'b1111;
      ordy     = 1'b1;
      in_data  = {D3, D2, D1, D0};
      rst3     = 1'b1;
      mode3    = 1'b0;
      sel3     = 2'd0;
      vld3     = 3'b111;
      ordy3    = 1'b1;
      in_data3 = {8'hC2, 8'hB1, 8'hA0};
`ifdef STREAM_MUX_LOCK_EN
      in_last  = 4'b1111;
      in_last3 = 3'b111;
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready",  64'(rdy), 64'h0);
      chk("reset.out_valid", 64'(ov),  64'h0);
      chk("reset.out_data",  64'(od),  64'h0);
      chk("reset.out_sel",   64'(os),  64'h0);
      chk("reset3.out_valid", 64'(ov3), 64'h0);
      chk("reset3.in_ready",  64'(rdy3), 64'h0);

      for (int i = 0; i < 28; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // N=3: illegal SEL=3 never grants; round-robin wraps 2 -> 0.
      step3(1'b0, 2'd0, 3'b111, 3'b001, 1'b1, 8'hA0, 2'd0, "n3.fixed0");
      step3(1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 8'hA0, 2'd0, "n3.sel_illegal");
      step3(1'b0, 2'd2, 3'b111, 3'b100, 1'b1, 8'hC2, 2'd2, "n3.fixed2");
      step3(1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 8'hA0, 2'd0, "n3.rr0");
      step3(1'b1, 2'd0, 3'b111, 3'b010, 1'b1, 8'hB1, 2'd1, "n3.rr1");
      step3(1'b1, 2'd0, 3'b111, 3'b100, 1'b1, 8'hC2, 2'd2, "n3.rr2");
      step3(1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 8'hA0, 2'd0, "n3.rr_wrap");
      step3(1'b1, 2'd0, 3'b000, 3'b000, 1'b0, 8'hA0, 2'd0, "n3.idle");

`ifdef STREAM_MUX_LOCK_EN
      // 3-beat packet on ch1 while ch0 also requests.
      apply('{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0}, "lock.reset");
      chk("lock.reset.out_last", 64'(out_last), 64'h0);
      @(negedge clk);
      rst = 1'b0; mode = 1'b1; vld = 4'b0010; in_last = 4'b0000; ordy = 1'b1;
      #1 chk("lock.b1.in_ready", 64'(rdy), 64'b0010);
      @(posedge clk); #1;
      chk("lock.b1.out_sel", 64'(os), 64'd1);
      chk("lock.b1.out_last", 64'(out_last), 64'h0);
      @(negedge clk);
      mode = 1'b0; sel = 2'd0; vld = 4'b0011; in_last = 4'b0000;
      #1 chk("lock.b2.in_ready", 64'(rdy), 64'b0010);
      @(posedge clk); #1;
      chk("lock.b2.out_sel", 64'(os), 64'd1);
      chk("lock.b2.out_last", 64'(out_last), 64'h0);
      @(negedge clk);
      mode = 1'b1; vld = 4'b0011; in_last = 4'b0010;
      #1 chk("lock.b3.in_ready", 64'(rdy), 64'b0010);
      @(posedge clk); #1;
      chk("lock.b3.out_sel", 64'(os), 64'd1);
      chk("lock.b3.out_last", 64'(out_last), 64'h1);
      @(negedge clk);
      vld = 4'b0011; in_last = 4'b1111;
      #1 chk("lock.after.in_ready", 64'(rdy), 64'b0001);
      @(posedge clk); #1;
      chk("lock.after.out_sel", 64'(os), 64'd0);
      chk("lock.after.out_data", 64'(od), 64'(D0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
Parametrised N:1 datapath multiplexer with per-channel valid/ready handshake and a registered output stage; the next generation of the core's combinational word muxes. Source selection is either fixed (by SEL) or round-robin arbitrated among valid requesters. It sits between multiple word producers (e.g. load/CSR/ALU result sources, bus masters) and a single consumer that may stall.

Parameters:
WIDTH, 32, data word width in bits (>=1)
N, 4, number of input channels (>=2, need not be a power of two)
SELW, $clog2(N), derived localparam, width of SEL/OUT_SEL; not overridable

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous reset, active-high
MODE  input  1  0 = fixed select via SEL, 1 = round-robin
SEL  input  SELW  channel index used when MODE=0
IN_VALID  input  N  per-channel beat valid
IN_DATA  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
IN_READY  output  N  per-channel accept, at most one bit set
OUT_VALID  output  1  registered beat valid
OUT_DATA  output  WIDTH  registered beat data
OUT_SEL  output  SELW  index of channel that supplied OUT_DATA
OUT_READY  input  1  consumer accept

Behaviour:
- Clock CLK, reset RST: one clock; reset is synchronous and active-high.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, round-robin pointer LAST=N-1, so channel 0 has first priority. IN_READY is combinational and forced to 0 while RST=1.
- Load enable: LD = !OUT_VALID || OUT_READY. The output register is a single-entry pipeline stage with full throughput, one beat per cycle under continuous valid/ready.
- Grant (combinational, same cycle):
  - MODE=0: G=SEL if SEL<N and IN_VALID[SEL]; otherwise no grant. SEL>=N never grants and never asserts IN_READY.
  - MODE=1: G = first i with IN_VALID[i], scanning LAST+1, LAST+2 ... modulo N. No grant if IN_VALID=0.
- IN_READY[G]=LD when a grant exists; all other bits 0. IN_READY depends on IN_VALID in this block; upstream must not make IN_VALID depend on IN_READY.
- Transfer on channel G when IN_VALID[G] && IN_READY[G]. At the next edge: OUT_DATA<=IN_DATA[G], OUT_SEL<=G, OUT_VALID<=1, and LAST<=G (both modes).
- If LD=1 with no grant: OUT_VALID<=0; OUT_DATA and OUT_SEL hold their values.
- If LD=0 (stall): all outputs hold and are stable until OUT_READY=1.
- Latency: exactly 1 cycle from input acceptance to OUT_VALID.
- MODE and SEL are sampled every cycle. A change takes effect on the same-cycle grant and never corrupts a held output beat.
- Reset asserted mid-stall discards the held beat. No input is accepted in a cycle where RST=1.

Optional Feature:
Macro STREAM_MUX_LOCK_EN.
- Defined: adds port IN_LAST (input, N bits) and output OUT_LAST (1 bit, reset 0, registered alongside data).
  - After a transfer with IN_LAST[G]=0, the block locks to G. Only G may be granted, in both modes, until a beat with IN_LAST[G]=1 is transferred.
  - MODE and SEL are ignored while locked.
  - Reset clears the lock.
- Undefined: no IN_LAST/OUT_LAST ports and no lock state; every beat is arbitrated independently.

Decomposition:
- Package stream_mux_pkg:
  - enum mux_mode_t {MODE_FIXED=1'b0, MODE_RR=1'b1}
  - default WIDTH/N localparams
  - function rr_next(valid, last) returning grant index and found flag
- One natural sub-module, rr_arbiter: N-bit rotating-priority arbiter with the LAST pointer, grant one-hot and index outputs, and an advance strobe. The top level holds the mux and output register.

Test Plan:
- Reset/fixed mode (N=4): MODE=0, SEL=2, IN_VALID=4'b0100, data2=0xDEADBEEF, OUT_READY=1 -> IN_READY=4'b0100 same cycle; next cycle OUT_VALID=1, OUT_DATA=0xDEADBEEF, OUT_SEL=2.
- Round-robin fairness: MODE=1, IN_VALID=4'b1111 held 8 cycles, OUT_READY=1 -> OUT_SEL sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- Backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> IN_READY=0, OUT_DATA/OUT_SEL stable; OUT_READY=1 -> next beat loads the following cycle with no loss or duplicate.
- Sparse RR: LAST=1, IN_VALID=4'b0011 -> grant 0, then 1, then 0.
- Illegal select with N=3: MODE=0, SEL=3, IN_VALID=3'b111 -> IN_READY=0, OUT_VALID falls to 0.
- Reset mid-stall: OUT_VALID=1, OUT_READY=0, RST=1 for 1 cycle -> OUT_VALID=0, OUT_SEL=0, next RR grant is channel 0. With STREAM_MUX_LOCK_EN: a 3-beat packet on ch1 (IN_LAST on beat 3) with ch0 valid -> ch0 is not granted until after beat 3.
